// File: rtl/cache_controller.sv
// cache_controller: ACE-style line-state controller for a single cache line request.
// Ports:
//   clk, reset (async, active-high)
//   cache_hit, cache_miss, line_state[2:0], cpu_request[1:0], ace_ready  -- inputs
//   read_req, write_req, invalid_req                                      -- bus requests
//   write_from_cpu, write_from_interconnect, cache_complete, cache_ready  -- status
//   new_state[2:0]                                                        -- committed line state
// Optional: define CACHE_CONTROLLER_ACE_TIMEOUT_EN to abandon a bus request after 255 cycles.
module cache_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       cache_hit,
    input  logic       cache_miss,
    input  logic [2:0] line_state,
    input  logic [1:0] cpu_request,
    input  logic       ace_ready,
    output logic       read_req,
    output logic       write_req,
    output logic       invalid_req,
    output logic       write_from_cpu,
    output logic       write_from_interconnect,
    output logic       cache_complete,
    output logic       cache_ready,
    output logic [2:0] new_state
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_FILL = 2'd2, S_UPD = 2'd3;
    localparam logic [1:0] K_NONE = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2, K_INV = 2'd3;
    logic [1:0] r_state, r_kind;
    logic [2:0] r_target, r_new_state;
    logic       r_wcpu;
    logic [2:0] w_ls, w_target;
    logic [1:0] w_kind;
    logic       w_hit, w_go;
    // Encodings 101-111 collapse to I; a hit on an invalid line is really a miss.
    assign w_ls   = line_state[2] ? 3'b100 : line_state;
    assign w_hit  = cache_hit & ~cache_miss & ~line_state[2];
    assign w_go   = (cache_hit | cache_miss) & (cpu_request != 2'b11);
    // Shared lines (SC/SD) have w_ls[1] set and need an upgrade before a write.
    assign w_kind = cpu_request == 2'b10 ? K_NONE :
                    cpu_request == 2'b00 ? (w_hit ? K_NONE : K_READ) :
                    !w_hit ? K_WRITE : (w_ls[1] ? K_INV : K_NONE);
    assign w_target = cpu_request == 2'b10 ? 3'b100 :
                      cpu_request == 2'b00 ? (w_hit ? w_ls : 3'b001) : 3'b000;
`ifdef CACHE_CONTROLLER_ACE_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [2:0] r_ls;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
            r_ls  <= 3'b100;
        end else begin
            r_cnt <= r_state == S_BUS ? r_cnt + 8'd1 : 8'd0;
            r_ls  <= (r_state == S_IDLE && w_go) ? w_ls : r_ls;
        end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_kind      <= K_NONE;
            r_target    <= 3'b100;
            r_wcpu      <= 1'b0;
            r_new_state <= 3'b100;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_kind   <= w_kind;
                    r_target <= w_target;
                    r_wcpu   <= cpu_request == 2'b01;
                    r_state  <= w_kind == K_NONE ? S_UPD : S_BUS;
                    if (w_kind == K_NONE) r_new_state <= w_target;
                end
                S_BUS: if (ace_ready) begin
                    r_state <= r_kind == K_INV ? S_UPD : S_FILL;
                    if (r_kind == K_INV) r_new_state <= r_target;
                end
`ifdef CACHE_CONTROLLER_ACE_TIMEOUT_EN
                // 255th cycle without ace_ready: give up and restore the captured state.
                else if (r_cnt == 8'd254) begin
                    r_state     <= S_UPD;
                    r_wcpu      <= 1'b0;
                    r_new_state <= r_ls;
                end
`endif
                S_FILL: begin
                    r_state     <= S_UPD;
                    r_new_state <= r_target;
                end
                S_UPD: r_state <= S_IDLE;
            endcase
        end
    end
    assign read_req                = r_state == S_BUS && r_kind == K_READ;
    assign write_req               = r_state == S_BUS && r_kind == K_WRITE;
    assign invalid_req             = r_state == S_BUS && r_kind == K_INV;
    assign write_from_interconnect = r_state == S_FILL;
    assign write_from_cpu          = r_state == S_UPD && r_wcpu;
    assign cache_complete          = r_state == S_UPD;
    assign cache_ready             = r_state == S_IDLE;
    assign new_state               = r_new_state;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed self-checking bench for cache_controller.
module tb_cache_controller;
    logic       clk, reset, cache_hit, cache_miss, ace_ready;
    logic [2:0] line_state;
    logic [1:0] cpu_request;
    logic       read_req, write_req, invalid_req, write_from_cpu;
    logic       write_from_interconnect, cache_complete, cache_ready;
    logic [2:0] new_state;
    logic [6:0] outs;
    int         n_tests, n_fail;
    cache_controller dut (
        .clk(clk), .reset(reset), .cache_hit(cache_hit), .cache_miss(cache_miss),
        .line_state(line_state), .cpu_request(cpu_request), .ace_ready(ace_ready),
        .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
        .write_from_cpu(write_from_cpu), .write_from_interconnect(write_from_interconnect),
        .cache_complete(cache_complete), .cache_ready(cache_ready), .new_state(new_state)
    );
    // {rd, wr, inv, wcpu, wfi, cmp, rdy}
    assign outs = {read_req, write_req, invalid_req, write_from_cpu,
                   write_from_interconnect, cache_complete, cache_ready};
    localparam logic [6:0] V_IDLE = 7'b0000001, V_UPD = 7'b0000010, V_UPDW = 7'b0001010;
    localparam logic [6:0] V_BRD = 7'b1000000, V_BWR = 7'b0100000, V_BINV = 7'b0010000;
    localparam logic [6:0] V_FILL = 7'b0000100;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic issue(input logic h, input logic m, input logic [2:0] ls, input logic [1:0] rq);
        cache_hit = h; cache_miss = m; line_state = ls; cpu_request = rq;
        tick();
        cache_hit = 0; cache_miss = 0; cpu_request = 2'b11;
    endtask
    task automatic ace();
        ace_ready = 1;
        tick();
        ace_ready = 0;
    endtask
    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1; cache_hit = 0; cache_miss = 0; ace_ready = 0;
        line_state = 3'b100; cpu_request = 2'b11;
        @(negedge clk); @(negedge clk);
        check("reset_outs", outs, V_IDLE);
        check("reset_ns", new_state, 3'b100);
        reset = 0;
        tick();
        // read hit on UC
        issue(1, 0, 3'b001, 2'b00);
        check("rdhit_upd", outs, V_UPD);
        check("rdhit_ns", new_state, 3'b001);
        tick();
        check("rdhit_idle", outs, V_IDLE);
        check("rdhit_hold_ns", new_state, 3'b001);
        // no-op request and stray ace_ready are ignored
        issue(1, 0, 3'b000, 2'b11);
        check("noop_idle", outs, V_IDLE);
        ace();
        check("ace_idle", outs, V_IDLE);
        // write miss on I
        issue(0, 1, 3'b100, 2'b01);
        check("wrmiss_bus0", outs, V_BWR);
        cache_hit = 1;
        tick();
        cache_hit = 0;
        check("wrmiss_bus1", outs, V_BWR);
        tick();
        check("wrmiss_bus2", outs, V_BWR);
        ace();
        check("wrmiss_fill", outs, V_FILL);
        tick();
        check("wrmiss_upd", outs, V_UPDW);
        check("wrmiss_ns", new_state, 3'b000);
        tick();
        check("wrmiss_idle", outs, V_IDLE);
        // write hit on SC: upgrade, no fill
        issue(1, 0, 3'b010, 2'b01);
        check("wrsc_bus0", outs, V_BINV);
        tick();
        check("wrsc_bus1", outs, V_BINV);
        ace();
        check("wrsc_upd", outs, V_UPDW);
        check("wrsc_ns", new_state, 3'b000);
        tick();
        check("wrsc_idle", outs, V_IDLE);
        // hit and miss together on a read -> miss path
        issue(1, 1, 3'b011, 2'b00);
        check("hm_bus", outs, V_BRD);
        ace();
        check("hm_fill", outs, V_FILL);
        tick();
        check("hm_upd", outs, V_UPD);
        check("hm_ns", new_state, 3'b001);
        tick();
        // invalidate hit on UC
        issue(1, 0, 3'b001, 2'b10);
        check("inv_upd", outs, V_UPD);
        check("inv_ns", new_state, 3'b100);
        tick();
        // write hit on UD: no bus traffic
        issue(1, 0, 3'b000, 2'b01);
        check("wrud_upd", outs, V_UPDW);
        check("wrud_ns", new_state, 3'b000);
        tick();
        // hit on reserved encoding 110 behaves as miss
        issue(1, 0, 3'b110, 2'b00);
        check("rsv_bus", outs, V_BRD);
        ace();
        tick();
        check("rsv_upd", outs, V_UPD);
        check("rsv_ns", new_state, 3'b001);
        tick();
        // reset while write_req is pending
        issue(0, 1, 3'b100, 2'b01);
        check("rst_pre", outs, V_BWR);
        #2 reset = 1;
        #1;
        check("rst_async_outs", outs, V_IDLE);
        check("rst_async_ns", new_state, 3'b100);
        @(negedge clk);
        reset = 0;
        tick();
        check("rst_after", outs, V_IDLE);
        tick();
        check("rst_no_cmp", outs, V_IDLE);
`ifdef CACHE_CONTROLLER_ACE_TIMEOUT_EN
        begin
            int cnt;
            cnt = 0;
            issue(0, 1, 3'b010, 2'b00);
            while (read_req === 1'b1 && cnt < 300) begin
                cnt++;
                tick();
            end
            check("to_cycles", cnt, 255);
            check("to_upd", outs, V_UPD);
            check("to_ns", new_state, 3'b010);
            tick();
            check("to_idle", outs, V_IDLE);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: cache_hit  in  1  tag lookup hit, qualifies a request in IDLE.
REQ-004 SHALL have: cache_miss  in  1  tag lookup miss, qualifies a request in IDLE.
REQ-005 SHALL have: line_state  in  3  current line state: 000 UD, 001 UC, 010 SC, 011 SD, 100 I; 101-111 treated as I.
REQ-006 SHALL have: cpu_request  in  2  00 read, 01 write, 10 invalidate, 11 no-op.
REQ-007 SHALL have: ace_ready  in  1  interconnect completion for the pending bus request.
REQ-008 SHALL have outputs, each 1 bit: read_req (ReadShared), write_req (ReadUnique), invalid_req (CleanUnique upgrade), write_from_cpu (data-array write of CPU data), write_from_interconnect (line fill), cache_complete (one-cycle done pulse), cache_ready (idle, accepting).
REQ-009 SHALL have: new_state  out  3  line state to commit, same encoding as line_state.

Function
REQ-010 SHALL implement FSM states IDLE, BUS_REQ, FILL, UPDATE; all outputs are decoded from registered state/registers (Moore).
REQ-011 In IDLE, cache_ready=1; on a rising edge with (cache_hit|cache_miss)=1 and cpu_request!=11, SHALL capture cpu_request and line_state and leave IDLE; otherwise SHALL stay in IDLE.
REQ-012 cache_hit and cache_miss both high SHALL be treated as miss; hit with line_state I SHALL be treated as miss.
REQ-013 Read hit, or invalidate hit/miss: IDLE->UPDATE; cache_complete one cycle after the capture edge.
REQ-014 Write hit in UD/UC: IDLE->UPDATE, write_from_cpu=1 in UPDATE, new_state=000.
REQ-015 Write hit in SC/SD: IDLE->BUS_REQ with invalid_req=1; on ace_ready sampled high ->UPDATE with write_from_cpu=1, new_state=000.
REQ-016 Read miss: BUS_REQ with read_req=1; on ace_ready ->FILL (write_from_interconnect=1 for exactly one cycle) ->UPDATE, new_state=001.
REQ-017 Write miss: BUS_REQ with write_req=1; on ace_ready ->FILL ->UPDATE with write_from_cpu=1, new_state=000.
REQ-018 BUS_REQ SHALL hold its single request output high continuously until ace_ready is sampled high; ace_ready outside BUS_REQ SHALL be ignored.
REQ-019 At most one of read_req/write_req/invalid_req SHALL be high in any cycle.
REQ-020 UPDATE SHALL last one cycle with cache_complete=1, then return to IDLE; new_state for read hit = captured line_state, for invalidate = 100.
REQ-021 new_state SHALL be registered and hold its last committed value until the next UPDATE.
REQ-022 cache_ready SHALL be 0 in every non-IDLE state; hit/miss inputs outside IDLE SHALL be ignored.

Reset
REQ-023 reset high SHALL immediately force IDLE regardless of clk, including mid-operation.
REQ-024 Reset values: read_req, write_req, invalid_req, write_from_cpu, write_from_interconnect, cache_complete = 0; cache_ready = 1; new_state = 100.
REQ-025 A request aborted by reset SHALL produce no cache_complete pulse.

Configuration
REQ-026 Macro CACHE_CONTROLLER_ACE_TIMEOUT_EN: when defined, an 8-bit counter SHALL run in BUS_REQ; if ace_ready is not sampled within 255 cycles, the request output SHALL drop and the FSM SHALL go to UPDATE with cache_complete=1, write_from_cpu=0, new_state = captured line_state.
REQ-027 Without the macro, BUS_REQ SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-028 Reset, line_state=001, cpu_request=00, cache_hit one cycle -> cache_complete=1 next cycle, new_state=001, no bus request, cache_ready returns 1.
REQ-029 line_state=100, cpu_request=01, cache_miss -> write_req=1 until ace_ready pulse; then write_from_interconnect one cycle; then write_from_cpu=1, cache_complete=1, new_state=000.
REQ-030 line_state=010, cpu_request=01, cache_hit -> invalid_req=1 until ace_ready; then write_from_cpu=1, cache_complete=1, new_state=000; write_from_interconnect never 1.
REQ-031 cpu_request=00, cache_hit=cache_miss=1 -> read_req path; after ace_ready, fill then new_state=001.
REQ-032 reset asserted while write_req=1 -> write_req=0, cache_ready=1 same cycle, new_state=100, no cache_complete.
REQ-033 With CACHE_CONTROLLER_ACE_TIMEOUT_EN, read miss with ace_ready held 0 -> read_req high 255 cycles, then cache_complete=1, new_state = captured line_state.
